// File: rtl/lsu_handshake_if.sv
// ---------------------------------------------------------------------------
// lsu_handshake_if / lsu_mem_if
//
// Purpose: bundles for the load/store unit.
//   lsu_handshake_if : MEM-stage side (request in, response/busy out).
//     modport master : pipeline side that issues accesses.
//     modport slave  : load/store unit side.
//     Signals: req_valid, req_ready, req_we, req_size, req_unsigned,
//              req_addr (byte address), req_wdata, resp_valid, resp_err,
//              resp_rdata, busy.
//   lsu_mem_if : memory side (request/grant, then read response).
//     modport master : load/store unit side.
//     modport slave  : memory side.
//     Signals: mem_req, mem_gnt, mem_we, mem_addr (word address),
//              mem_wstrb, mem_wdata, mem_rvalid, mem_rdata.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

interface lsu_handshake_if #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 16
);
  localparam int OFF_W = $clog2(XLEN / 8);

  logic                    req_valid;
  logic                    req_ready;
  logic                    req_we;
  logic [1:0]              req_size;
  logic                    req_unsigned;
  logic [ADDR_W+OFF_W-1:0] req_addr;
  logic [XLEN-1:0]         req_wdata;
  logic                    resp_valid;
  logic                    resp_err;
  logic [XLEN-1:0]         resp_rdata;
  logic                    busy;

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_err, resp_rdata, busy
  );

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready, resp_valid, resp_err, resp_rdata, busy
  );
endinterface

interface lsu_mem_if #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 16
);
  logic                mem_req;
  logic                mem_gnt;
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_addr;
  logic [XLEN/8-1:0]   mem_wstrb;
  logic [XLEN-1:0]     mem_wdata;
  logic                mem_rvalid;
  logic [XLEN-1:0]     mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
    output mem_gnt, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/lsu_handshake.sv
// ---------------------------------------------------------------------------
// lsu_handshake
//
// Purpose: MEM-stage load/store unit. Accepts one access at a time from the
// pipeline, checks alignment, issues a request/grant transaction to a memory
// that may stall, extracts/extends load data and returns a one-cycle
// response. busy stalls the pipeline while an access is in flight.
//
// Ports:
//   clk   : clock, rising edge
//   rst   : synchronous active-high reset
//   core  : lsu_handshake_if.slave (req_*, resp_*, busy)
//   mem   : lsu_mem_if.master      (mem_*)
//
// Optional feature: define LSU_TIMEOUT_EN to build a watchdog that ends a
// stalled REQ/WAIT_R after TIMEOUT_CYC cycles with resp_err=1.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module lsu_handshake #(
  parameter int XLEN        = 32,
  parameter int ADDR_W      = 16,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic           clk,
  input  logic           rst,
  lsu_handshake_if.slave core,
  lsu_mem_if.master      mem
);
  localparam int STRB_W = XLEN / 8;
  localparam int OFF_W  = $clog2(STRB_W);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_R, RESP} state_t;
  state_t state_reg, state_next;

  logic              mem_req_reg, mem_req_next;
  logic              mem_we_reg, mem_we_next;
  logic [ADDR_W-1:0] mem_addr_reg, mem_addr_next;
  logic [STRB_W-1:0] mem_wstrb_reg, mem_wstrb_next;
  logic [XLEN-1:0]   mem_wdata_reg, mem_wdata_next;
  logic              resp_valid_reg, resp_valid_next;
  logic              resp_err_reg, resp_err_next;
  logic [XLEN-1:0]   resp_rdata_reg, resp_rdata_next;
  logic [1:0]        size_reg, size_next;
  logic              unsigned_reg, unsigned_next;
  logic [OFF_W-1:0]  off_reg, off_next;
  logic              err_reg, err_next;
  logic [XLEN-1:0]   load_reg, load_next;

  logic              accept;
  logic [OFF_W-1:0]  req_off;
  logic              misaligned;
  logic [STRB_W-1:0] strb_base;
  logic [STRB_W-1:0] store_strb;
  logic [XLEN-1:0]   store_data;
  logic [XLEN-1:0]   rdata_shifted;
  logic [XLEN-1:0]   load_ext;
  logic              fill_bit;
  logic              timeout;

  genvar gi;

  assign core.req_ready = (state_reg == IDLE) && !rst;
  assign core.busy      = (state_reg != IDLE);
  assign accept         = core.req_valid && core.req_ready;
  assign req_off        = core.req_addr[OFF_W-1:0];

  // Size 3 is only legal on a 64-bit datapath.
  always_comb begin
    misaligned = 1'b0;
    case (core.req_size)
      2'd0:    misaligned = 1'b0;
      2'd1:    misaligned = req_off[0];
      2'd2:    misaligned = |req_off[1:0];
      default: misaligned = (XLEN == 32) ? 1'b1 : |req_off;
    endcase
  end

  always_comb begin
    strb_base = '1;
    case (core.req_size)
      2'd0:    strb_base = STRB_W'(1);
      2'd1:    strb_base = STRB_W'(3);
      2'd2:    strb_base = STRB_W'(15);
      default: strb_base = '1;
    endcase
  end
  assign store_strb = strb_base << req_off;

  // Replicate the right-aligned store operand so whichever lanes the strobe
  // selects already carry the right byte.
  for (gi = 0; gi < STRB_W; gi++) begin : g_lane
    logic [7:0] lane;
    always_comb begin
      lane = core.req_wdata[8*gi +: 8];
      case (core.req_size)
        2'd0:    lane = core.req_wdata[7:0];
        2'd1:    lane = core.req_wdata[8*(gi%2) +: 8];
        2'd2:    lane = core.req_wdata[8*(gi%4) +: 8];
        default: lane = core.req_wdata[8*gi +: 8];
      endcase
    end
    assign store_data[8*gi +: 8] = lane;
  end

  // Load path: bring the addressed bytes down to bit 0, then fill the upper
  // bits with zeros or the sign bit of the accessed width.
  assign rdata_shifted = mem.mem_rdata >> {off_reg, 3'b000};

  always_comb begin
    fill_bit = 1'b0;
    case (size_reg)
      2'd0:    fill_bit = rdata_shifted[7];
      2'd1:    fill_bit = rdata_shifted[15];
      2'd2:    fill_bit = rdata_shifted[31];
      default: fill_bit = 1'b0;
    endcase
    fill_bit = fill_bit && !unsigned_reg;
  end

  for (gi = 0; gi < XLEN; gi++) begin : g_ext
    logic keep;
    always_comb begin
      keep = 1'b1;
      case (size_reg)
        2'd0:    keep = (gi < 8);
        2'd1:    keep = (gi < 16);
        2'd2:    keep = (gi < 32);
        default: keep = 1'b1;
      endcase
    end
    assign load_ext[gi] = keep ? rdata_shifted[gi] : fill_bit;
  end

  always_comb begin
    state_next     = state_reg;
    mem_req_next   = mem_req_reg;
    mem_we_next    = mem_we_reg;
    mem_addr_next  = mem_addr_reg;
    mem_wstrb_next = mem_wstrb_reg;
    mem_wdata_next = mem_wdata_reg;
    size_next      = size_reg;
    unsigned_next  = unsigned_reg;
    off_next       = off_reg;
    err_next       = err_reg;
    load_next      = load_reg;
    // The response registers are loaded while leaving RESP, so the pulse
    // lands in the cycle after RESP and is low otherwise.
    resp_valid_next = (state_reg == RESP);
    resp_err_next   = (state_reg == RESP) && err_reg;
    resp_rdata_next = ((state_reg == RESP) && !err_reg && !mem_we_reg) ? load_reg : '0;

    case (state_reg)
      IDLE: begin
        if (accept) begin
          size_next     = core.req_size;
          unsigned_next = core.req_unsigned;
          off_next      = req_off;
          err_next      = misaligned;
          load_next     = '0;
          if (misaligned) begin
            state_next = RESP;
          end else begin
            state_next     = REQ;
            mem_req_next   = 1'b1;
            mem_we_next    = core.req_we;
            mem_addr_next  = core.req_addr[ADDR_W+OFF_W-1:OFF_W];
            mem_wstrb_next = core.req_we ? store_strb : '0;
            mem_wdata_next = core.req_we ? store_data : '0;
          end
        end
      end
      REQ: begin
        if (mem.mem_gnt) begin
          mem_req_next = 1'b0;
          state_next   = mem_we_reg ? RESP : WAIT_R;
        end else if (timeout) begin
          mem_req_next = 1'b0;
          err_next     = 1'b1;
          state_next   = RESP;
        end
      end
      WAIT_R: begin
        if (mem.mem_rvalid) begin
          load_next  = load_ext;
          state_next = RESP;
        end else if (timeout) begin
          err_next   = 1'b1;
          state_next = RESP;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

`ifdef LSU_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             waiting;

  assign waiting = (state_reg == REQ) || (state_reg == WAIT_R);
  assign timeout = waiting && (cnt_reg == CNT_W'(TIMEOUT_CYC));

  // Restart on every entry to a waiting state; saturate rather than wrap.
  always_comb begin
    cnt_next = cnt_reg;
    if ((state_next != state_reg) && ((state_next == REQ) || (state_next == WAIT_R)))
      cnt_next = '0;
    else if (waiting && (cnt_reg != CNT_W'(TIMEOUT_CYC)))
      cnt_next = cnt_reg + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_reg <= '0;
    else     cnt_reg <= cnt_next;
  end
`else
  // Without the watchdog the unit waits for the memory indefinitely.
  logic unused_timeout_cyc;
  assign unused_timeout_cyc = |TIMEOUT_CYC;
  assign timeout            = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      mem_req_reg    <= 1'b0;
      mem_we_reg     <= 1'b0;
      mem_addr_reg   <= '0;
      mem_wstrb_reg  <= '0;
      mem_wdata_reg  <= '0;
      resp_valid_reg <= 1'b0;
      resp_err_reg   <= 1'b0;
      resp_rdata_reg <= '0;
      size_reg       <= '0;
      unsigned_reg   <= 1'b0;
      off_reg        <= '0;
      err_reg        <= 1'b0;
      load_reg       <= '0;
    end else begin
      state_reg      <= state_next;
      mem_req_reg    <= mem_req_next;
      mem_we_reg     <= mem_we_next;
      mem_addr_reg   <= mem_addr_next;
      mem_wstrb_reg  <= mem_wstrb_next;
      mem_wdata_reg  <= mem_wdata_next;
      resp_valid_reg <= resp_valid_next;
      resp_err_reg   <= resp_err_next;
      resp_rdata_reg <= resp_rdata_next;
      size_reg       <= size_next;
      unsigned_reg   <= unsigned_next;
      off_reg        <= off_next;
      err_reg        <= err_next;
      load_reg       <= load_next;
    end
  end

  assign mem.mem_req     = mem_req_reg;
  assign mem.mem_we      = mem_we_reg;
  assign mem.mem_addr    = mem_addr_reg;
  assign mem.mem_wstrb   = mem_wstrb_reg;
  assign mem.mem_wdata   = mem_wdata_reg;
  assign core.resp_valid = resp_valid_reg;
  assign core.resp_err   = resp_err_reg;
  assign core.resp_rdata = resp_rdata_reg;

endmodule

// File: tb/tb_lsu_handshake.sv
// ---------------------------------------------------------------------------
// tb_lsu_handshake
//
// Purpose: self-checking bench for lsu_handshake (XLEN=32). A byte-addressed
// reference memory predicts load results; a word memory with programmable
// grant/read delays plays the memory side. Directed accesses first, then a
// randomized sequence, a reset during an outstanding load, and a summary.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_lsu_handshake;
  localparam int XLEN   = 32;
  localparam int ADDR_W = 16;
  localparam int OFF_W  = 2;
  localparam int BA_W   = ADDR_W + OFF_W;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  lsu_handshake_if #(.XLEN(XLEN), .ADDR_W(ADDR_W)) core_if ();
  lsu_mem_if       #(.XLEN(XLEN), .ADDR_W(ADDR_W)) mem_if ();

  lsu_handshake #(.XLEN(XLEN), .ADDR_W(ADDR_W), .TIMEOUT_CYC(255)) dut (
    .clk  (clk),
    .rst  (rst),
    .core (core_if),
    .mem  (mem_if)
  );

  int          vectors     = 0;
  int          miscompares = 0;
  int          txn_id      = 0;
  logic [31:0] mem_words [0:255];
  logic [7:0]  ref_mem   [0:1023];
  logic [31:0] last_rdata;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic put_word(input int w, input logic [31:0] v);
    mem_words[w] = v;
    for (int i = 0; i < 4; i++) ref_mem[4*w+i] = v[8*i +: 8];
  endtask

  // One access; called at a negedge with the DUT idle.
  task automatic do_access(input logic we, input logic [1:0] size, input logic uns,
                           input int addr, input logic [31:0] wdata,
                           input int gd, input int rd);
    int n, lat, k, resp_at, resp_cnt, req_cycles, gcnt, rcnt, bad_busy, bad_stable, m, w;
    bit mis, granted, rv_done;
    logic [31:0] exp_rd, exp_wdata, v, got_rd, snap_wdata;
    logic [3:0]  exp_strb, snap_strb;
    logic [15:0] snap_addr;
    logic        got_err, snap_we;

    n   = 1 << size;
    mis = (size == 2'd3) || ((addr % n) != 0);
    lat = mis ? 2 : (we ? 3 + gd : 4 + gd + rd);

    exp_rd = '0;
    if (!mis && !we) begin
      v = '0;
      for (int i = 0; i < n; i++) v = v | (32'(ref_mem[addr+i]) << (8*i));
      if (!uns && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
      exp_rd = v;
    end
    m        = ((1 << n) - 1) << (addr % 4);
    exp_strb = m[3:0];
    exp_wdata = '0;
    if (n <= 4)
      for (int j = 0; j < 4; j++) exp_wdata[8*j +: 8] = wdata[8*(j % n) +: 8];

    core_if.req_valid    = 1'b1;
    core_if.req_we       = we;
    core_if.req_size     = size;
    core_if.req_unsigned = uns;
    core_if.req_addr     = BA_W'(addr);
    core_if.req_wdata    = wdata;
    #1;
    check("req_ready_at_request", core_if.req_ready, 1);

    granted = 0; rv_done = 0; gcnt = 0; rcnt = 0; req_cycles = 0;
    resp_at = -1; resp_cnt = 0; bad_busy = 0; bad_stable = 0;
    got_err = 1'bx; got_rd = 'x;
    snap_addr = '0; snap_we = 1'b0; snap_strb = '0; snap_wdata = '0;

    for (k = 1; k <= lat + 2; k++) begin
      @(negedge clk);
      core_if.req_valid    = 1'b0;
      core_if.req_addr     = BA_W'($urandom);
      core_if.req_wdata    = $urandom;
      core_if.req_size     = 2'($urandom);
      mem_if.mem_gnt       = 1'b0;
      mem_if.mem_rvalid    = 1'b0;
      mem_if.mem_rdata     = $urandom;

      if (core_if.resp_valid) begin
        resp_cnt++;
        if (resp_at < 0) begin
          resp_at = k;
          got_err = core_if.resp_err;
          got_rd  = core_if.resp_rdata;
        end
      end
      if (core_if.busy !== (k < lat))       bad_busy++;
      if (core_if.req_ready !== (k >= lat)) bad_busy++;

      if (mem_if.mem_req) begin
        req_cycles++;
        if (req_cycles == 1) begin
          snap_addr  = mem_if.mem_addr;
          snap_we    = mem_if.mem_we;
          snap_strb  = mem_if.mem_wstrb;
          snap_wdata = mem_if.mem_wdata;
        end else if (mem_if.mem_addr !== snap_addr || mem_if.mem_we !== snap_we ||
                     mem_if.mem_wstrb !== snap_strb || mem_if.mem_wdata !== snap_wdata) begin
          bad_stable++;
        end
        if (!granted) begin
          if (gcnt >= gd) begin
            mem_if.mem_gnt = 1'b1;
            granted        = 1;
            if (mem_if.mem_we) begin
              w = int'(mem_if.mem_addr[7:0]);
              for (int j = 0; j < 4; j++)
                if (mem_if.mem_wstrb[j]) mem_words[w][8*j +: 8] = mem_if.mem_wdata[8*j +: 8];
            end
          end else begin
            gcnt++;
          end
        end
      end else if (granted && !snap_we && !rv_done) begin
        if (rcnt >= rd) begin
          mem_if.mem_rvalid = 1'b1;
          mem_if.mem_rdata  = mem_words[int'(snap_addr[7:0])];
          rv_done           = 1;
        end else begin
          rcnt++;
        end
      end
    end

    check("resp_latency", resp_at, lat);
    check("resp_pulse_count", resp_cnt, 1);
    check("resp_err", got_err, mis);
    check("resp_rdata", got_rd, exp_rd);
    check("mem_req_cycles", req_cycles, mis ? 0 : gd + 1);
    check("busy_ready_timeline", bad_busy, 0);
    if (!mis) begin
      check("mem_outputs_stable", bad_stable, 0);
      check("mem_addr", snap_addr, addr >> 2);
      check("mem_we", snap_we, we);
      check("mem_wstrb", snap_strb, we ? exp_strb : 4'b0);
      if (we) check("mem_wdata", snap_wdata, exp_wdata);
    end

    if (we && !mis)
      for (int i = 0; i < n; i++) ref_mem[addr+i] = wdata[8*i +: 8];

    last_rdata = got_rd;
    txn_id++;
    $display("txn %0d: %s size=%0d uns=%0b addr=0x%03h wdata=0x%08h gnt_dly=%0d rv_dly=%0d -> err=%0b rdata=0x%08h cycle=%0d",
             txn_id, we ? "ST" : "LD", size, uns, addr, wdata, gd, rd, got_err, got_rd, resp_at);
  endtask

  initial begin
    int rc, sz, a, n;

    rst                  = 1'b1;
    core_if.req_valid    = 1'b0;
    core_if.req_we       = 1'b0;
    core_if.req_size     = 2'd0;
    core_if.req_unsigned = 1'b0;
    core_if.req_addr     = '0;
    core_if.req_wdata    = '0;
    mem_if.mem_gnt       = 1'b0;
    mem_if.mem_rvalid    = 1'b0;
    mem_if.mem_rdata     = '0;
    for (int w = 0; w < 256; w++) put_word(w, $urandom);

    repeat (3) @(negedge clk);
    #1;
    check("rst_req_ready", core_if.req_ready, 0);
    check("rst_busy", core_if.busy, 0);
    check("rst_mem_req", mem_if.mem_req, 0);
    check("rst_mem_we", mem_if.mem_we, 0);
    check("rst_mem_addr", mem_if.mem_addr, 0);
    check("rst_mem_wstrb", mem_if.mem_wstrb, 0);
    check("rst_mem_wdata", mem_if.mem_wdata, 0);
    check("rst_resp_valid", core_if.resp_valid, 0);
    check("rst_resp_err", core_if.resp_err, 0);
    check("rst_resp_rdata", core_if.resp_rdata, 0);
    @(negedge clk);
    rst = 1'b0;

    // Directed cases
    put_word(0, 32'h80FF_1234);
    do_access(1'b0, 2'd0, 1'b0, 3, 32'h0, 0, 0);
    check("lb_sign_ext", last_rdata, 32'hFFFF_FF80);
    put_word(0, 32'h8001_ABCD);
    do_access(1'b0, 2'd1, 1'b1, 2, 32'h0, 0, 0);
    check("lhu_zero_ext", last_rdata, 32'h0000_8001);
    do_access(1'b0, 2'd1, 1'b0, 2, 32'h0, 0, 0);
    check("lh_sign_ext", last_rdata, 32'hFFFF_8001);
    do_access(1'b1, 2'd0, 1'b0, 1, 32'h0000_00A5, 0, 0);
    do_access(1'b0, 2'd2, 1'b0, 0, 32'h0, 0, 0);
    check("sb_readback", last_rdata, 32'h8001_A5CD);
    do_access(1'b1, 2'd1, 1'b0, 3, 32'h0000_BEEF, 0, 0);
    do_access(1'b1, 2'd2, 1'b0, 8, 32'hDEAD_BEEF, 5, 0);
    do_access(1'b0, 2'd2, 1'b0, 8, 32'h0, 2, 3);
    check("sw_readback", last_rdata, 32'hDEAD_BEEF);
    do_access(1'b0, 2'd3, 1'b0, 16, 32'h0, 0, 0);
    do_access(1'b1, 2'd1, 1'b0, 6, 32'h1234_5678, 1, 0);
    do_access(1'b0, 2'd0, 1'b1, 7, 32'h0, 0, 2);

    // Reset while a load waits for read data
    core_if.req_valid = 1'b1;
    core_if.req_we    = 1'b0;
    core_if.req_size  = 2'd2;
    core_if.req_addr  = BA_W'(16);
    @(negedge clk);
    core_if.req_valid = 1'b0;
    check("rstmid_mem_req", mem_if.mem_req, 1);
    mem_if.mem_gnt = 1'b1;
    @(negedge clk);
    mem_if.mem_gnt = 1'b0;
    check("rstmid_busy_wait_r", core_if.busy, 1);
    rst = 1'b1;
    #1;
    check("rstmid_ready_in_rst", core_if.req_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rstmid_mem_req_drop", mem_if.mem_req, 0);
    check("rstmid_idle", core_if.busy, 0);
    check("rstmid_ready", core_if.req_ready, 1);
    mem_if.mem_rvalid = 1'b1;
    mem_if.mem_rdata  = 32'hCAFE_F00D;
    rc = 0;
    repeat (4) begin
      @(negedge clk);
      mem_if.mem_rvalid = 1'b0;
      if (core_if.resp_valid || core_if.busy) rc++;
    end
    check("rstmid_no_response", rc, 0);

    // Randomized sequence
    for (int t = 0; t < 80; t++) begin
      sz = $urandom_range(0, 3);
      n  = 1 << sz;
      a  = $urandom_range(0, 1023);
      if ($urandom_range(0, 3) != 0) a = a & ~(n - 1);
      do_access(1'($urandom), 2'(sz), 1'($urandom), a, $urandom,
                $urandom_range(0, 3), $urandom_range(0, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
